pipe_fetch_stage: RTL and testbench
===================================

Name: pipe_fetch_stage

Overview:
- Instruction-fetch stage of the pipelined MIPS core. Owns the PC and drives the instruction-memory read port (Avalon-style, with waitrequest).
- Produces the IF/ID register: IF_ID_Instruction, IF_ID_valid and the PC values. The downstream decode/control stage consumes these.
- Honours the global waitrequest freeze, hazard-unit stalls and taken branch/jump redirects (one architectural delay slot).
- Detects the halt condition (jump to address 0) and misaligned targets.

Parameters:
- RESET_VECTOR, 32'hBFC00000, PC value loaded on reset.
- HALT_ADDR, 32'h00000000, fetch address that stops the core.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high reset
- waitrequest  in  1  memory busy; freezes whole pipeline
- stall  in  1  load-use stall from hazard unit; hold PC and IF/ID
- branch_taken  in  1  redirect request resolved in ID
- branch_target  in  32  redirect target address
- instr_readdata  in  32  fetched word
- instr_read  out  1  read strobe
- instr_address  out  32  fetch address (= PC)
- IF_ID_Instruction  out  32  instruction into ID
- IF_ID_valid  out  1  IF/ID contents valid
- IF_ID_PC  out  32  address of IF_ID_Instruction
- IF_ID_PCPlus8  out  32  link value (IF_ID_PC+8)
- active  out  1  high until fetch has halted or faulted
- fetch_fault  out  1  sticky, misaligned fetch target

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-access):
  - PC=RESET_VECTOR, state=RUN.
  - IF_ID_Instruction=0, IF_ID_valid=0, IF_ID_PC=0, IF_ID_PCPlus8=0.
  - fetch_fault=0.
  - active=1 after reset deasserts.
- States:
  - RUN: fetching.
  - HALTED: fetch stopped by halt.
  - FAULT: fetch stopped by misaligned PC.
- Combinational outputs:
  - instr_address = PC.
  - instr_read = (state==RUN) && PC!=HALT_ADDR && PC[1:0]==0 && !stall.
  - active = (state==RUN).
- Advance condition: adv = (state==RUN) && !waitrequest && !stall && PC!=HALT_ADDR && PC[1:0]==0.
- On adv, at the clock edge:
  - IF_ID_Instruction <= instr_readdata.
  - IF_ID_valid <= 1.
  - IF_ID_PC <= PC.
  - IF_ID_PCPlus8 <= PC+8.
  - PC <= branch_taken ? branch_target : PC+4. Arithmetic is mod 2^32; PC+4 wraps from 32'hFFFFFFFC to 0 and then halts.
- Delay slot: the word fetched in the same cycle that branch_taken is high is the delay slot and is never squashed. The redirect applies to the following fetch.
- waitrequest=1: every register holds, including IF_ID_valid. instr_read and instr_address stay stable until waitrequest falls.
- stall=1 with waitrequest=0:
  - PC and all IF/ID registers hold.
  - branch_taken is ignored; ID re-presents it after the stall.
  - No read is issued.
- Simultaneous stall and branch_taken: stall wins.
- Simultaneous waitrequest and stall: waitrequest wins; full hold.
- In RUN with PC==HALT_ADDR and !waitrequest && !stall, at the edge: state <= HALTED, IF_ID_valid <= 0.
- In RUN with PC[1:0]!=0 (and PC!=HALT_ADDR) and !waitrequest && !stall, at the edge: state <= FAULT, fetch_fault <= 1, IF_ID_valid <= 0.
- HALTED and FAULT are terminal until reset:
  - instr_read=0.
  - IF_ID_valid=0.
  - IF_ID_Instruction holds its last value.
  - Downstream stages drain independently.
- instr_readdata is sampled only on adv. Its value in any other cycle is don't-care, including X.

Test Plan:
- Reset, no stalls, memory returns 32'h24020005 at BFC00000 and 32'h24030007 at BFC00004.
  - Required: addresses BFC00000, BFC00004, BFC00008 in consecutive cycles.
  - Required: IF_ID_Instruction=24020005, IF_ID_PC=BFC00000, PCPlus8=BFC00008, valid=1 one edge after reset release.
- waitrequest high 3 cycles during fetch of BFC00004.
  - Required: instr_read=1 and address=BFC00004 held throughout.
  - Required: IF/ID unchanged.
  - Required: captured on the first edge with waitrequest=0.
- stall=1 for 1 cycle at PC=BFC00008, together with branch_taken=1, target=BFC00100.
  - Required: no read, PC and IF/ID hold.
  - Next cycle (stall=0, branch_taken=1): fetch BFC00008 (delay slot), then BFC00100.
- branch_taken=1 with target=0.
  - Required: delay slot at PC captured with valid=1.
  - Required: following cycle instr_read=0; next edge state=HALTED, IF_ID_valid=0, active=0.
  - Required: stays halted for 10 cycles.
- branch_taken=1 with target=BFC00102.
  - Required: delay slot fetched, then instr_read=0, fetch_fault=1, active=0, valid=0.
- Assert reset mid-waitrequest while in HALTED.
  - Required: outputs clear immediately without a clock.
  - Required: after release, fetch resumes at BFC00000 with active=1.

Source files
------------

// File: rtl/pipe_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory read port
// and fills the IF/ID register, stopping for good on a halt or a misaligned target.
module pipe_fetch_stage #(
   parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
   parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        waitrequest,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic [31:0] instr_readdata,
   output logic        instr_read,
   output logic [31:0] instr_address,
   output logic [31:0] IF_ID_Instruction,
   output logic        IF_ID_valid,
   output logic [31:0] IF_ID_PC,
   output logic [31:0] IF_ID_PCPlus8,
   output logic        active,
   output logic        fetch_fault
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      HALTED = 2'd1,
      FAULT  = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [31:0] pc;
   logic        running;
   logic        at_halt;
   logic        misaligned;
   logic        go;
   logic        adv;

   // go: the pipeline is allowed to move this cycle; adv: it also fetches a word
   assign running    = (state == RUN);
   assign at_halt    = (pc == HALT_ADDR);
   assign misaligned = (pc[1:0] != 2'b00);
   assign go         = running && !waitrequest && !stall;
   assign adv        = go && !at_halt && !misaligned;

   assign instr_address = pc;
   assign instr_read    = running && !at_halt && !misaligned && !stall;
   assign active        = running;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= RUN;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      if (go && at_halt) begin
         state_next = HALTED;
      end else if (go && misaligned) begin
         state_next = FAULT;
      end
   end

   // The redirect applies to the fetch after this one, so the word read now is the delay slot
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc                <= RESET_VECTOR;
         IF_ID_Instruction <= 32'h0;
         IF_ID_valid       <= 1'b0;
         IF_ID_PC          <= 32'h0;
         IF_ID_PCPlus8     <= 32'h0;
         fetch_fault       <= 1'b0;
      end else if (adv) begin
         IF_ID_Instruction <= instr_readdata;
         IF_ID_valid       <= 1'b1;
         IF_ID_PC          <= pc;
         IF_ID_PCPlus8     <= pc + 32'd8;
         pc                <= branch_taken ? branch_target : pc + 32'd4;
      end else if (go) begin
         IF_ID_valid <= 1'b0;
         if (!at_halt) begin
            fetch_fault <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pipe_fetch_stage.sv
// Bench for pipe_fetch_stage: directed and random fetch traffic scored against
// a cycle-level reference model through decoupled expectation queues.
module tb_pipe_fetch_stage;

   localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;

   logic        clk;
   logic        reset;
   logic        waitrequest;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic [31:0] instr_readdata;
   logic        instr_read;
   logic [31:0] instr_address;
   logic [31:0] IF_ID_Instruction;
   logic        IF_ID_valid;
   logic [31:0] IF_ID_PC;
   logic [31:0] IF_ID_PCPlus8;
   logic        active;
   logic        fetch_fault;

   typedef struct {
      logic        rd;
      logic [31:0] addr;
      logic        act;
      logic        valid_after;
      logic        fault_after;
      logic        act_after;
   } status_t;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc8;
   } fetch_t;

   status_t     stq[$];
   fetch_t      fq[$];
   int          vectors = 0;
   int          miscompares = 0;
   logic        mon_en = 1'b0;

   // Reference model: 0 = fetching, 1 = halted, 2 = faulted
   logic [31:0] m_pc;
   int          m_state;
   logic        m_valid;
   logic        m_fault;

   pipe_fetch_stage dut (
      .clk              (clk),
      .reset            (reset),
      .waitrequest      (waitrequest),
      .stall            (stall),
      .branch_taken     (branch_taken),
      .branch_target    (branch_target),
      .instr_readdata   (instr_readdata),
      .instr_read       (instr_read),
      .instr_address    (instr_address),
      .IF_ID_Instruction(IF_ID_Instruction),
      .IF_ID_valid      (IF_ID_valid),
      .IF_ID_PC         (IF_ID_PC),
      .IF_ID_PCPlus8    (IF_ID_PCPlus8),
      .active           (active),
      .fetch_fault      (fetch_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] memWord(input logic [31:0] addr);
      if (addr == 32'hBFC00000) return 32'h24020005;
      if (addr == 32'hBFC00004) return 32'h24030007;
      return (addr * 32'h9E3779B1) ^ 32'h0BADF00D;
   endfunction

   assign instr_readdata = instr_read ? memWord(instr_address) : 32'hxxxxxxxx;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic modelReset();
      m_pc    = RESET_VECTOR;
      m_state = 0;
      m_valid = 1'b0;
      m_fault = 1'b0;
   endtask

   // One cycle, called at a falling edge: drive inputs, predict, wait for next falling edge
   task automatic applyStimulus(input logic w, input logic s, input logic bt, input logic [31:0] tgt);
      status_t st;
      fetch_t  f;
      mon_en        = 1'b1;
      waitrequest   = w;
      stall         = s;
      branch_taken  = bt;
      branch_target = tgt;
      st.rd   = (m_state == 0) && (m_pc != 32'h0) && (m_pc[1:0] == 2'b00) && !s;
      st.addr = m_pc;
      st.act  = (m_state == 0);
      if (m_state == 0 && !w && !s) begin
         if (m_pc == 32'h0) begin
            m_state = 1;
            m_valid = 1'b0;
         end else if (m_pc[1:0] != 2'b00) begin
            m_state = 2;
            m_fault = 1'b1;
            m_valid = 1'b0;
         end else begin
            f.instr = memWord(m_pc);
            f.pc    = m_pc;
            f.pc8   = m_pc + 32'd8;
            fq.push_back(f);
            m_valid = 1'b1;
            m_pc    = bt ? tgt : m_pc + 32'd4;
         end
      end
      st.valid_after = m_valid;
      st.fault_after = m_fault;
      st.act_after   = (m_state == 0);
      stq.push_back(st);
      @(negedge clk);
   endtask

   task automatic doReset();
      mon_en       = 1'b0;
      waitrequest  = 1'b0;
      stall        = 1'b0;
      branch_taken = 1'b0;
      reset        = 1'b1;
      #1;
      checkOutput("reset_valid", {31'b0, IF_ID_valid}, 32'h0);
      checkOutput("reset_fault", {31'b0, fetch_fault}, 32'h0);
      checkOutput("reset_addr", instr_address, RESET_VECTOR);
      @(negedge clk);
      reset = 1'b0;
      modelReset();
   endtask

   // Monitor: checks pre-edge port status, then scores IF/ID whenever a read is accepted
   initial begin
      status_t st;
      fetch_t  f;
      logic    hs;
      forever begin
         @(negedge clk);
         #2;
         if (mon_en) begin
            if (stq.size() == 0) begin
               checkOutput("status_queue_empty", 32'h1, 32'h0);
            end else begin
               st = stq.pop_front();
               checkOutput("instr_read", {31'b0, instr_read}, {31'b0, st.rd});
               checkOutput("instr_address", instr_address, st.addr);
               checkOutput("active", {31'b0, active}, {31'b0, st.act});
               hs = instr_read && !waitrequest;
               @(posedge clk);
               #1;
               if (hs) begin
                  if (fq.size() == 0) begin
                     checkOutput("unexpected_fetch", IF_ID_PC, 32'hFFFFFFFF);
                  end else begin
                     f = fq.pop_front();
                     checkOutput("IF_ID_Instruction", IF_ID_Instruction, f.instr);
                     checkOutput("IF_ID_PC", IF_ID_PC, f.pc);
                     checkOutput("IF_ID_PCPlus8", IF_ID_PCPlus8, f.pc8);
                  end
               end
               checkOutput("IF_ID_valid", {31'b0, IF_ID_valid}, {31'b0, st.valid_after});
               checkOutput("fetch_fault", {31'b0, fetch_fault}, {31'b0, st.fault_after});
               checkOutput("active_after", {31'b0, active}, {31'b0, st.act_after});
            end
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired at %0t", $time);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int          term_cycles;
      logic [31:0] tgt;
      int          r;
      reset         = 1'b1;
      waitrequest   = 1'b0;
      stall         = 1'b0;
      branch_taken  = 1'b0;
      branch_target = 32'h0;
      modelReset();
      @(negedge clk);
      doReset();

      // straight-line fetch, waitrequest freeze, stall with pending branch, branch to halt
      applyStimulus(0, 0, 0, 32'h0);
      repeat (3) applyStimulus(1, 0, 0, 32'h0);
      applyStimulus(0, 0, 0, 32'h0);
      applyStimulus(0, 1, 1, 32'hBFC00100);
      applyStimulus(0, 0, 1, 32'hBFC00100);
      applyStimulus(0, 0, 0, 32'h0);
      applyStimulus(0, 0, 1, 32'h0);
      applyStimulus(0, 0, 0, 32'h0);
      repeat (10) applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), $urandom);

      // asynchronous reset in the middle of a waitrequest cycle while halted
      mon_en      = 1'b0;
      waitrequest = 1'b1;
      #2;
      checkOutput("halted_hold_instr", IF_ID_Instruction, memWord(32'hBFC00104));
      reset = 1'b1;
      #1;
      checkOutput("async_instr", IF_ID_Instruction, 32'h0);
      checkOutput("async_pc", IF_ID_PC, 32'h0);
      checkOutput("async_pc8", IF_ID_PCPlus8, 32'h0);
      checkOutput("async_valid", {31'b0, IF_ID_valid}, 32'h0);
      checkOutput("async_addr", instr_address, RESET_VECTOR);
      @(negedge clk);
      reset       = 1'b0;
      waitrequest = 1'b0;
      modelReset();

      // misaligned branch target
      applyStimulus(0, 0, 0, 32'h0);
      applyStimulus(0, 0, 1, 32'hBFC00102);
      repeat (4) applyStimulus(0, 0, 0, 32'h0);

      // PC wrap from the top of the address space into the halt address
      doReset();
      applyStimulus(0, 0, 1, 32'hFFFFFFF8);
      repeat (5) applyStimulus(0, 0, 0, 32'h0);

      // randomized traffic, re-resetting a few cycles after each halt or fault
      doReset();
      term_cycles = 0;
      for (int i = 0; i < 400; i++) begin
         if (m_state != 0) term_cycles++;
         if (term_cycles >= 3) begin
            doReset();
            term_cycles = 0;
         end else begin
            r = $urandom_range(0, 99);
            if (r < 3) tgt = 32'h0;
            else if (r < 6) tgt = RESET_VECTOR + ($urandom_range(0, 255) << 2) + 32'd2;
            else tgt = RESET_VECTOR + ($urandom_range(0, 255) << 2);
            applyStimulus($urandom_range(0, 99) < 25, $urandom_range(0, 99) < 20,
                          $urandom_range(0, 99) < 15, tgt);
         end
      end

      mon_en = 1'b0;
      #30;
      checkOutput("fetch_queue_drained", fq.size(), 32'h0);
      checkOutput("status_queue_drained", stq.size(), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
